// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stage: flag bit positions, the buffer
// occupancy states, and a helper that packs the four condition flags.
package alu_pkg;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  function automatic logic [3:0] make_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO with registered outputs.
// head_q always holds the oldest entry and keeps its last value when empty.
module alu_skid_fifo2
  import alu_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output occ_state_t   state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready_o depends on occupancy only, never on out_ready_i.
  occ_state_t   state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = head_q;
  assign state_o     = state_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= in_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= in_data_i;
          end else if (push) begin
            tail_q  <= in_data_i;
            state_q <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage_8bit.sv
// Registered output stage after the 8-bit adder: buffers {flags, sum} in a
// 2-entry FIFO and tracks a sticky overflow flag plus a saturating event count.
module alu_result_stage_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             clr_status,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_state_t       occ_state;
  logic [3:0]       in_flags;
  logic             accept;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  // The adder already zeroes Sum on overflow, so V=1 naturally yields Z=1, N=0.
  assign in_flags = make_flags(in_overflow, in_carry, in_sum[WIDTH-1], in_sum == '0);
  assign accept   = in_valid & in_ready;

  alu_skid_fifo2 #(.W(WIDTH + 4)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({in_flags, in_sum}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  ({out_flags, out_result}),
    .state_o     (occ_state)
  );

  // An overflow accept beats a same-cycle clear: the count restarts at 1.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (accept && in_overflow) begin
      sticky_d = 1'b1;
      if (clr_status)              count_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end else if (clr_status) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign sticky_ovf = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_alu_result_stage_8bit.sv
// Directed bench for alu_result_stage_8bit: a cycle table of inputs and
// expected outputs, plus hand sequences for reset, streaming and saturation.
module tb_alu_result_stage_8bit;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, in_carry, in_overflow;
  logic [7:0] in_sum;
  logic       out_valid, out_ready, clr_status, sticky_ovf;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] ovf_count;

  logic       b_in_valid, b_in_ready, b_in_carry, b_in_overflow;
  logic [7:0] b_in_sum;
  logic       b_out_valid, b_out_ready, b_clr_status, b_sticky_ovf;
  logic [7:0] b_out_result;
  logic [3:0] b_out_flags;
  logic [1:0] b_ovf_count;

  alu_result_stage_8bit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .clr_status(clr_status), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  alu_result_stage_8bit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
    .in_carry(b_in_carry), .in_overflow(b_in_overflow),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_flags(b_out_flags),
    .clr_status(b_clr_status), .sticky_ovf(b_sticky_ovf), .ovf_count(b_ovf_count)
  );

  typedef struct {
    logic       v;
    logic [7:0] sum;
    logic       c;
    logic       o;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic       e_inrdy;
    logic [7:0] e_res;
    logic [3:0] e_flags;
    logic       e_sticky;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic v, input logic [7:0] sum, input logic c, input logic o,
                         input logic rdy, input logic clr, input logic ev, input logic eir,
                         input logic [7:0] er, input logic [3:0] ef, input logic es,
                         input logic [7:0] ec);
    vec_t t;
    t = '{v, sum, c, o, rdy, clr, ev, eir, er, ef, es, ec};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [7:0] sum, input logic c, input logic o,
                       input logic rdy, input logic clr);
    in_valid = v; in_sum = sum; in_carry = c; in_overflow = o;
    out_ready = rdy; clr_status = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    b_in_valid = 0; b_in_sum = 8'h00; b_in_carry = 0; b_in_overflow = 0;
    b_out_ready = 0; b_clr_status = 0;

    //      v  sum    c  o  rdy clr | valid inrdy res    flags    st cnt
    add_vec(1, 8'h05, 0, 0, 1, 0,     1,    1,    8'h05, 4'b0000, 0, 8'd0);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'h05, 4'b0000, 0, 8'd0);
    add_vec(1, 8'h00, 1, 1, 0, 0,     1,    1,    8'h00, 4'b1101, 1, 8'd1);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'h00, 4'b1101, 1, 8'd1);
    add_vec(1, 8'h80, 0, 0, 0, 0,     1,    1,    8'h80, 4'b0010, 1, 8'd1);
    add_vec(1, 8'h7F, 0, 0, 0, 0,     1,    0,    8'h80, 4'b0010, 1, 8'd1);
    add_vec(1, 8'hAA, 1, 0, 0, 0,     1,    0,    8'h80, 4'b0010, 1, 8'd1);
    add_vec(1, 8'hAA, 1, 0, 1, 0,     1,    1,    8'h7F, 4'b0000, 1, 8'd1);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'h7F, 4'b0000, 1, 8'd1);
    add_vec(1, 8'hFF, 1, 0, 1, 0,     1,    1,    8'hFF, 4'b0110, 1, 8'd1);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'hFF, 4'b0110, 1, 8'd1);
    add_vec(1, 8'h00, 1, 0, 0, 0,     1,    1,    8'h00, 4'b0101, 1, 8'd1);
    add_vec(1, 8'h00, 0, 1, 0, 0,     1,    0,    8'h00, 4'b0101, 1, 8'd2);
    add_vec(0, 8'h00, 0, 0, 1, 0,     1,    1,    8'h00, 4'b1001, 1, 8'd2);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'h00, 4'b1001, 1, 8'd2);
    add_vec(0, 8'h00, 0, 0, 0, 1,     0,    1,    8'h00, 4'b1001, 0, 8'd0);
    add_vec(1, 8'h00, 1, 1, 1, 1,     1,    1,    8'h00, 4'b1101, 1, 8'd1);
    add_vec(0, 8'h00, 0, 0, 1, 0,     0,    1,    8'h00, 4'b1101, 1, 8'd1);

    #12;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_result", 32'(out_result), 32'h00);
    check("rst out_flags", 32'(out_flags), 32'h0);
    check("rst sticky", 32'(sticky_ovf), 32'd0);
    check("rst count", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].sum, vecs[i].c, vecs[i].o, vecs[i].rdy, vecs[i].clr);
      step();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_inrdy));
      check($sformatf("vec%0d out_result", i), 32'(out_result), 32'(vecs[i].e_res));
      check($sformatf("vec%0d out_flags", i), 32'(out_flags), 32'(vecs[i].e_flags));
      check($sformatf("vec%0d sticky", i), 32'(sticky_ovf), 32'(vecs[i].e_sticky));
      check($sformatf("vec%0d count", i), 32'(ovf_count), 32'(vecs[i].e_cnt));
    end

    // Streaming: hold ONE with a push and a pop every cycle.
    drive(1, 8'h11, 0, 0, 0, 0);
    exp_q.push_back(8'h11);
    step();
    check("stream start state", 32'(dut.occ_state), 32'(ONE));
    for (int k = 0; k < 10; k++) begin
      drive(1, 8'(8'h20 + k), 0, 0, 1, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check($sformatf("stream%0d underflow", k), 32'd1, 32'd0);
        else check($sformatf("stream%0d data", k), 32'(out_result), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(in_sum);
      step();
      check($sformatf("stream%0d state", k), 32'(dut.occ_state), 32'(ONE));
    end
    drive(0, 8'h00, 0, 0, 1, 0);
    if (exp_q.size() == 0) check("stream drain underflow", 32'd1, 32'd0);
    else check("stream drain data", 32'(out_result), 32'(exp_q.pop_front()));
    step();
    check("stream leftover", 32'(exp_q.size()), 32'd0);
    check("stream end valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL with a nonzero counter.
    drive(1, 8'h00, 1, 1, 0, 0);
    step();
    drive(1, 8'h33, 0, 0, 0, 0);
    step();
    check("pre-reset in_ready", 32'(in_ready), 32'd0);
    check("pre-reset count", 32'(ovf_count), 32'd2);
    drive(0, 8'h00, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst count", 32'(ovf_count), 32'd0);
    check("async rst sticky", 32'(sticky_ovf), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post-reset out_valid", 32'(out_valid), 32'd0);

    // Saturating counter on the CNT_W=2 instance.
    b_in_valid = 1; b_in_sum = 8'h00; b_in_carry = 1; b_in_overflow = 1; b_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("sat%0d count", k), 32'(b_ovf_count), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end
    check("sat in_ready", 32'(b_in_ready), 32'd1);
    b_clr_status = 1;
    step();
    check("clr+ovf count", 32'(b_ovf_count), 32'd1);
    check("clr+ovf sticky", 32'(b_sticky_ovf), 32'd1);
    b_in_valid = 0;
    step();
    check("clr count", 32'(b_ovf_count), 32'd0);
    check("clr sticky", 32'(b_sticky_ovf), 32'd0);
    b_clr_status = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
